// File: rtl/bist_misr_analyzer.sv
// BIST response analyzer: compacts PATTERNS circuit-under-test responses into a
// multiple-input signature register and compares the final signature with GOLDEN.
module bist_misr_analyzer #(
  parameter int               WIDTH    = 3,
  parameter logic [WIDTH-1:0] TAPS     = 3'b010,
  parameter int               PATTERNS = 7,
  parameter logic [WIDTH-1:0] SEED     = 3'b000,
  parameter logic [WIDTH-1:0] GOLDEN   = 3'b000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_in,
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_CHECK
  } state_e;

  localparam logic [7:0] LAST_COUNT = 8'(PATTERNS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [7:0]       count_q, count_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [WIDTH-1:0] misr_next;
  logic [7:0]       count_inc;

  // Shift by one stage, fold the MSB back into the tapped stages, then mix in the response.
  always_comb begin
    misr_next    = '0;
    misr_next[0] = sig_q[WIDTH-1] ^ resp_in[0];
    for (int i = 1; i < WIDTH; i++) begin
      misr_next[i] = sig_q[i-1] ^ (TAPS[i] & sig_q[WIDTH-1]) ^ resp_in[i];
    end
  end

  assign count_inc = count_q + 8'd1;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    sig_d   = sig_q;
    count_d = count_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sig_d   = SEED;
          count_d = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (abort) begin
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = S_IDLE;
        end else if (resp_valid) begin
          sig_d   = misr_next;
          count_d = count_inc;
          if (count_inc == LAST_COUNT) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (abort) begin
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end else begin
          pass_d  = (sig_q == GOLDEN);
          fail_d  = (sig_q != GOLDEN);
          done_d  = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      count_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      count_q <= count_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign signature = sig_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

  a_verdict_exclusive : assert property (@(posedge clock) disable iff (!reset) !(pass_q && fail_q));
  a_done_single_cycle : assert property (@(posedge clock) disable iff (!reset) done_q |=> !done_q);
  a_count_in_range    : assert property (@(posedge clock) disable iff (!reset) count_q <= LAST_COUNT);

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Self-checking bench: directed sessions pinned to hand-computed signatures plus a
// randomized run, all compared every cycle against a session-level reference model.
module tb_bist_misr_analyzer;

  localparam int         W        = 3;
  localparam logic [2:0] TAPS     = 3'b010;
  localparam int         PATTERNS = 7;
  localparam logic [2:0] SEED     = 3'b000;
  localparam logic [2:0] GOLDEN   = 3'b000;

  logic       clock = 1'b0;
  logic       reset, start, abort, resp_valid;
  logic [2:0] resp_in;
  logic [2:0] signature;
  logic       busy, done, pass, fail;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  bist_misr_analyzer #(
    .WIDTH(W), .TAPS(TAPS), .PATTERNS(PATTERNS), .SEED(SEED), .GOLDEN(GOLDEN)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .resp_valid(resp_valid), .resp_in(resp_in), .signature(signature),
    .busy(busy), .done(done), .pass(pass), .fail(fail)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signature as a shift-and-xor polynomial step; session tracked as a phase.
  function automatic logic [2:0] misr_step(input logic [2:0] s, input logic [2:0] d);
    logic [2:0] shifted;
    logic [2:0] fb;
    shifted = s << 1;
    fb      = s[W-1] ? (TAPS | 3'b001) : 3'b000;
    return shifted ^ fb ^ d;
  endfunction

  localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_VERDICT = 2;
  int         m_phase;
  int         m_cnt;
  logic [2:0] m_sig;
  logic       m_done, m_pass, m_fail;

  always @(posedge clock) begin
    if (!reset) begin
      m_phase = PH_IDLE; m_sig = SEED; m_cnt = 0;
      m_done = 0; m_pass = 0; m_fail = 0;
    end else begin
      m_done = 0;
      if (m_phase == PH_IDLE) begin
        if (start) begin
          m_phase = PH_COLLECT; m_sig = SEED; m_cnt = 0; m_pass = 0; m_fail = 0;
        end
      end else if (abort) begin
        m_phase = PH_IDLE; m_pass = 0; m_fail = 0;
      end else if (m_phase == PH_COLLECT) begin
        if (resp_valid) begin
          m_sig = misr_step(m_sig, resp_in);
          m_cnt++;
          if (m_cnt == PATTERNS) m_phase = PH_VERDICT;
        end
      end else begin
        m_pass  = (m_sig == GOLDEN);
        m_fail  = !m_pass;
        m_done  = 1;
        m_phase = PH_IDLE;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("cyc_signature", signature, m_sig);
      check("cyc_busy", busy, m_phase != PH_IDLE);
      check("cyc_done", done, m_done);
      check("cyc_pass", pass, m_pass);
      check("cyc_fail", fail, m_fail);
      check("cyc_exclusive", pass & fail, 1'b0);
    end
  end

  task automatic drive(input logic rst, input logic st, input logic ab,
                       input logic rv, input logic [2:0] d);
    reset = rst; start = st; abort = ab; resp_valid = rv; resp_in = d;
    @(posedge clock);
    #2;
  endtask

  task automatic idle_cycle();
    drive(1, 0, 0, 0, 3'b000);
  endtask

  task automatic resp(input logic [2:0] d);
    drive(1, 0, 0, 1, d);
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (done !== 1'b1 && n < max) begin
      idle_cycle();
      n++;
    end
    check("done_seen", done, 1'b1);
  endtask

  logic [2:0] lit [7];

  // Start, seven responses (last one selectable, optional gap), then wait for the verdict.
  task automatic run_session(input int gap_after, input int gap_len,
                             input logic [2:0] last_d, output int total);
    int n;
    drive(1, 1, 0, 0, 3'b000);
    total = 1;
    for (int k = 0; k < 7; k++) begin
      if (k == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          idle_cycle();
          total++;
        end
      end
      resp(k == 6 ? last_d : 3'b001);
      total++;
      if (k < 6) check("lit_signature", signature, lit[k]);
    end
    wait_done(4, n);
    total += n;
    check("verdict_latency", n, 1);
  endtask

  initial begin
    int tot;
    int n;
    lit[0] = 3'b001; lit[1] = 3'b011; lit[2] = 3'b111; lit[3] = 3'b100;
    lit[4] = 3'b010; lit[5] = 3'b101; lit[6] = 3'b000;

    drive(0, 1, 0, 1, 3'b111);
    cmp_en = 1'b1;
    drive(0, 0, 0, 1, 3'b101);
    check("reset_signature", signature, 3'b000);
    check("reset_flags", {busy, done, pass, fail}, 4'b0000);
    idle_cycle();

    // Golden session: full signature sequence, pass verdict.
    run_session(-1, 0, 3'b001, tot);
    check("s036_final_sig", signature, 3'b000);
    check("s036_verdict", {done, pass, fail}, 3'b110);
    check("s036_edges", tot, 9);
    idle_cycle();
    check("s036_done_drop", {done, pass}, 2'b01);

    // Corrupted final response.
    run_session(-1, 0, 3'b000, tot);
    check("s037_final_sig", signature, 3'b001);
    check("s037_verdict", {done, pass, fail}, 3'b101);
    idle_cycle();

    // Three-cycle gap between responses 2 and 3.
    run_session(2, 3, 3'b001, tot);
    check("s038_verdict", {done, pass, fail}, 3'b110);
    check("s038_edges", tot, 12);
    idle_cycle();

    // Abort after four responses, then a clean session.
    drive(1, 1, 0, 0, 3'b000);
    repeat (4) resp(3'b001);
    drive(1, 1, 1, 1, 3'b001);
    check("s039_abort_sig", signature, 3'b100);
    check("s039_abort_flags", {busy, done, pass, fail}, 4'b0000);
    repeat (3) idle_cycle();
    check("s039_no_done", done, 1'b0);
    run_session(-1, 0, 3'b001, tot);
    check("s039_rerun_pass", {pass, fail}, 2'b10);
    idle_cycle();

    // Reset mid-session with start and responses toggling.
    drive(1, 1, 0, 0, 3'b000);
    repeat (3) resp(3'b001);
    check("s040_pre_sig", signature, 3'b111);
    drive(0, 1, 0, 1, 3'b110);
    drive(0, 1, 0, 1, 3'b011);
    check("s040_sig", signature, 3'b000);
    check("s040_flags", {busy, done, pass, fail}, 4'b0000);
    idle_cycle();
    idle_cycle();
    check("s040_after", {busy, done}, 2'b00);

    // Start while busy is ignored; start with done begins a new session.
    drive(1, 1, 0, 0, 3'b000);
    repeat (3) resp(3'b001);
    drive(1, 1, 0, 0, 3'b000);
    check("s041_ignored", {busy, signature}, {1'b1, 3'b111});
    repeat (4) resp(3'b001);
    wait_done(4, n);
    check("s041_pass", {pass, fail}, 2'b10);
    drive(1, 1, 0, 0, 3'b000);
    check("s041_restart", {busy, done, pass, fail, signature}, {4'b1000, 3'b000});
    for (int k = 0; k < 7; k++) resp(3'b001);
    wait_done(4, n);
    check("s041_second_pass", {pass, fail}, 2'b10);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 299) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 4) < 3,
            3'($urandom_range(0, 7)));
    end
    drive(0, 0, 0, 0, 3'b000);
    check("final_reset", {busy, done, pass, fail}, 4'b0000);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_misr_analyzer.md
BIST_MISR_ANALYZER -- requirements
Module: bist_misr_analyzer

Interface
REQ-001 Parameter WIDTH, default 3: width of the response bus and the signature register.
REQ-002 Parameter TAPS, default 3'b010: feedback mask, bit i set means the signature MSB feeds back into stage i (i >= 1).
REQ-003 Parameter PATTERNS, default 7: number of valid responses compacted per session, range 1..255.
REQ-004 Parameter SEED, default 3'b000: signature value loaded at session start.
REQ-005 Parameter GOLDEN, default 3'b000: expected final signature.
REQ-006 clock  input  1  Single clock; all state updates on its rising edge.
REQ-007 reset  input  1  Synchronous, active-low reset, sampled on the rising edge of clock.
REQ-008 start  input  1  Session start request.
REQ-009 abort  input  1  Terminates the session without a verdict.
REQ-010 resp_valid  input  1  Marks resp_in as a circuit-under-test response in this cycle.
REQ-011 resp_in  input  WIDTH  Circuit-under-test response word.
REQ-012 signature  output  WIDTH  Current MISR contents.
REQ-013 busy  output  1  High in states CAPTURE and CHECK.
REQ-014 done  output  1  One-cycle pulse when a verdict is produced.
REQ-015 pass  output  1  Final signature equals GOLDEN; held until the next accepted start or reset.
REQ-016 fail  output  1  Final signature differs from GOLDEN; held until the next accepted start or reset.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, CAPTURE and CHECK.
REQ-018 IDLE: start=1 SHALL load signature<=SEED, clear count, clear pass and fail, and enter CAPTURE; all other inputs are ignored.
REQ-019 CAPTURE: on each edge with resp_valid=1, the signature SHALL update as follows, with s=signature and d=resp_in:
- next[0] = s[WIDTH-1]^d[0]
- next[i] = s[i-1]^(TAPS[i]&s[WIDTH-1])^d[i], for i >= 1
REQ-020 CAPTURE: count SHALL increment by one per accepted response and be 8 bits wide (wrap-free, because PATTERNS <= 255).
REQ-021 CAPTURE: with resp_valid=0, signature and count SHALL hold; gaps of any length are legal.
REQ-022 CAPTURE: the edge that accepts response number PATTERNS SHALL move the FSM to CHECK.
REQ-023 CHECK (one cycle): responses SHALL be ignored and the signature SHALL hold; the next edge SHALL register pass=(signature==GOLDEN), fail=~pass and done=1, and return to IDLE.
REQ-024 Verdict latency SHALL be: done high in the second cycle after the edge that accepted the final response.
REQ-025 done SHALL be high for exactly one cycle per completed session.
REQ-026 pass and fail SHALL never be high simultaneously.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 start in the cycle where done=1 SHALL be accepted; pass and fail are cleared on that edge.
REQ-029 abort=1 in CAPTURE or CHECK SHALL return the FSM to IDLE on the next edge with done, pass and fail all 0; the signature holds its value.
REQ-030 abort in IDLE SHALL have no effect.
REQ-031 abort SHALL take priority over start and resp_valid in the same cycle.
REQ-032 resp_valid asserted in IDLE SHALL leave the signature unchanged.

Reset
REQ-033 reset=0 at a rising edge SHALL force state IDLE, signature=SEED, count=0, busy=0, done=0, pass=0 and fail=0, overriding every other input.
REQ-034 reset asserted mid-session SHALL discard the session; no done pulse is produced.
REQ-035 Outputs SHALL be valid from the first edge after reset deasserts.

Verification
REQ-036 Defaults; start, then 7 consecutive resp_valid cycles with resp_in=3'b001 -> signature sequence 001, 011, 111, 100, 010, 101, 000; done pulses one cycle with pass=1, fail=0.
REQ-037 Same as REQ-036 but the 7th response is 3'b000 -> final signature 3'b001; fail=1, pass=0.
REQ-038 Same as REQ-036 with resp_valid deasserted for 3 cycles between responses 2 and 3 -> identical signatures and verdict; done arrives 3 cycles later.
REQ-039 abort after 4 responses -> IDLE, signature 3'b100, no done; a subsequent session per REQ-036 passes.
REQ-040 reset=0 after 3 responses, then released -> signature 3'b000, all flags 0; start and resp_valid pulses during reset have no effect.
REQ-041 start pulsed during CAPTURE, and start coincident with done -> the first is ignored (count continues); the second starts a new session with pass cleared.
